// File: rtl/nou_fetch_mc_if.sv
// Request-FIFO read side and XRQ head side of the multi-channel NOU fetch stage.
// Signal names match the original block so existing netlists keep their names.
interface nou_fetch_mc_if #(
  parameter int NUM_CH = 2,
  parameter int CMD_W  = 64,
  parameter int SID_W  = 8,
  parameter int UOV_W  = 8,
  parameter int XRQ_AW = 3
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W = 1 + SID_W + CH_W + CMD_W + UOV_W;

  logic [NUM_CH*CMD_W-1:0] req_fifo_data_f1;
  logic [NUM_CH-1:0]       req_fifo_empty_f0;
  logic [NUM_CH-1:0]       req_fifo_rd_en_f0;
  logic [ENT_W-1:0]        xrq_entry_output;
  logic                    xrq_entry_output_valid;
  logic                    decode_issue_ack_in;
  logic [XRQ_AW:0]         xrq_count;

  modport slave (
    input  req_fifo_data_f1, req_fifo_empty_f0, decode_issue_ack_in,
    output req_fifo_rd_en_f0, xrq_entry_output, xrq_entry_output_valid, xrq_count
  );

  modport master (
    output req_fifo_data_f1, req_fifo_empty_f0, decode_issue_ack_in,
    input  req_fifo_rd_en_f0, xrq_entry_output, xrq_entry_output_valid, xrq_count
  );
endinterface

// File: rtl/nou_fetch_mc.sv
// Multi-channel XoCC request fetch: round-robin f0/f1 FIFO reads, predecode, SID allocation, XRQ.
// Optional NOU_FETCH_PERF_EN adds per-channel fetch counters and a stall counter.
module nou_fetch_mc #(
  parameter int NUM_CH = 2,
  parameter int CMD_W  = 64,
  parameter int TYPE_W = 4,
  parameter int SID_W  = 8,
  parameter int UOV_W  = 8,
  parameter int XRQ_AW = 3
) (
  input logic           clk,
  input logic           rstn,
  nou_fetch_mc_if.slave bus
`ifdef NOU_FETCH_PERF_EN
  ,
  output logic [NUM_CH*32-1:0] perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ENT_W = 1 + SID_W + CH_W + CMD_W + UOV_W;
  localparam int DEPTH = 2 ** XRQ_AW;
  localparam int CNT_W = XRQ_AW + 1;

  localparam logic [TYPE_W-1:0] T_GNT_BUF     = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] T_GNT_PKT_WL  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_SND_PKT_RID = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_SND_PKT     = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] T_REL_BUF     = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] T_REL_PKT_WL  = TYPE_W'(5);

  localparam logic [UOV_W-1:0] UM_IRR   = UOV_W'(8'h01);
  localparam logic [UOV_W-1:0] UM_BRR   = UOV_W'(8'h02);
  localparam logic [UOV_W-1:0] UM_PWRR  = UOV_W'(8'h04);
  localparam logic [UOV_W-1:0] UM_SPIDR = UOV_W'(8'h08);
  localparam logic [UOV_W-1:0] UM_SPRR  = UOV_W'(8'h10);

  typedef enum logic {LK_FREE, LK_HELD} lock_e;

  lock_e             lock_st_q, lock_st_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              f1_vld_q;
  logic [CH_W-1:0]   f1_ch_q, f1_ch_d;
  logic [SID_W-1:0]  sid_q, sid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XRQ_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic [CMD_W-1:0]  f1_cmd;
  logic [TYPE_W-1:0] f1_type;
  logic [UOV_W-1:0]  um;
  logic              push, pop, grant, gnt_vld, space;
  logic [CH_W-1:0]   gnt_ch;
  logic [NUM_CH-1:0] elig, rd_en;
  logic [CNT_W:0]    reserve;
  int unsigned       idx;

  assign f1_cmd  = bus.req_fifo_data_f1[int'(f1_ch_q)*CMD_W +: CMD_W];
  assign f1_type = f1_cmd[TYPE_W-1:0];
  assign push    = f1_vld_q;
  assign pop     = (cnt_q != '0) && bus.decode_issue_ack_in;

  always_comb begin
    um = UM_IRR;
    case (f1_type)
      T_GNT_BUF, T_REL_BUF:       um = UM_BRR;
      T_GNT_PKT_WL, T_REL_PKT_WL: um = UM_PWRR;
      T_SND_PKT_RID:              um = UM_SPIDR;
      T_SND_PKT:                  um = UM_SPRR;
      default:                    um = UM_IRR;
    endcase
  end

  always_comb begin
    lock_st_d = lock_st_q;
    lock_ch_d = lock_ch_q;
    if (f1_vld_q) begin
      if (f1_type == T_SND_PKT_RID) begin
        lock_st_d = LK_HELD;
        lock_ch_d = f1_ch_q;
      end else if (lock_st_q == LK_HELD && f1_ch_q == lock_ch_q) begin
        lock_st_d = LK_FREE;
      end
    end
  end

  // Eligibility follows the lock's next state so the f0 slot in the same cycle as a
  // SND_PKT_RID f1 already goes to the locked channel and the pair stays adjacent.
  always_comb begin
    elig = ~bus.req_fifo_empty_f0;
    if (lock_st_d == LK_HELD) elig = elig & (NUM_CH'(1) << lock_ch_d);
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_q) + i) % NUM_CH;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
    reserve = {1'b0, cnt_q} + (CNT_W+1)'(f1_vld_q) - (CNT_W+1)'(pop);
    space   = reserve < (CNT_W+1)'(DEPTH);
    // Strobe is gated by rstn so no FIFO read leaks out while reset is held.
    grant   = gnt_vld && space && rstn;
    rd_en   = grant ? (NUM_CH'(1) << gnt_ch) : '0;
    rr_d    = rr_q;
    f1_ch_d = f1_ch_q;
    if (grant) begin
      rr_d    = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      f1_ch_d = gnt_ch;
    end
  end

  always_comb begin
    sid_d = sid_q;
    if (push && um != UM_SPIDR) sid_d = (sid_q == '1) ? SID_W'(1) : sid_q + 1'b1;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_st_q <= LK_FREE;
      lock_ch_q <= '0;
      rr_q      <= '0;
      f1_vld_q  <= 1'b0;
      f1_ch_q   <= '0;
      sid_q     <= SID_W'(1);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      lock_st_q <= lock_st_d;
      lock_ch_q <= lock_ch_d;
      rr_q      <= rr_d;
      f1_vld_q  <= grant;
      f1_ch_q   <= f1_ch_d;
      sid_q     <= sid_d;
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {um, f1_cmd, f1_ch_q, sid_q, 1'b1};
  end

  assign bus.req_fifo_rd_en_f0      = rd_en;
  assign bus.xrq_entry_output_valid = (cnt_q != '0);
  assign bus.xrq_entry_output       = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.xrq_count              = cnt_q;

`ifdef NOU_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q [NUM_CH];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < NUM_CH; c++) fetch_cnt_q[c] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (push && 32'(f1_ch_q) == c && fetch_cnt_q[c] != '1)
          fetch_cnt_q[c] <= fetch_cnt_q[c] + 1'b1;
      end
      if ((|(~bus.req_fifo_empty_f0)) && rd_en == '0 && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    perf_fetch_cnt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) perf_fetch_cnt[c*32 +: 32] = fetch_cnt_q[c];
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_nou_fetch_mc.sv
// Directed bench for nou_fetch_mc (NUM_CH=2, XRQ_AW=3) with a queue-based request FIFO model.
module tb_nou_fetch_mc;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nou_fetch_mc_if #(.NUM_CH(2), .CMD_W(64), .SID_W(8), .UOV_W(8), .XRQ_AW(3)) bus ();

`ifdef NOU_FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  nou_fetch_mc #(.NUM_CH(2), .CMD_W(64), .TYPE_W(4), .SID_W(8), .UOV_W(8), .XRQ_AW(3)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef NOU_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [81:0] caps[$];
  int          grants[$];
  int          gnt_total = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [63:0] mk(int ch, int idx, logic [3:0] typ);
    return {8'hA5, 8'(ch), 16'(idx), 28'h0, typ};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    bus.req_fifo_empty_f0 = {q1.size() == 0, q0.size() == 0};
  endtask

  task automatic load(int ch, int n, logic [3:0] typ, int base);
    for (int k = 0; k < n; k++) begin
      if (ch == 0) q0.push_back(mk(0, base + k, typ));
      else         q1.push_back(mk(1, base + k, typ));
    end
    upd_empty();
  endtask

  // One cycle: sample just before the edge, then model the FIFO read data after it.
  task automatic step();
    logic [1:0] pend;
    #4;
    pend = bus.req_fifo_rd_en_f0;
    if (pend != 2'b00) begin
      grants.push_back(pend[1] ? 1 : 0);
      gnt_total++;
    end
    if (bus.xrq_entry_output_valid && bus.decode_issue_ack_in) caps.push_back(bus.xrq_entry_output);
    @(posedge clk);
    #1;
    if (pend[0] && q0.size() > 0) bus.req_fifo_data_f1[63:0]   = q0.pop_front();
    if (pend[1] && q1.size() > 0) bus.req_fifo_data_f1[127:64] = q1.pop_front();
    upd_empty();
    @(negedge clk);
  endtask

  task automatic wait_caps(int n, int budget);
    int k = 0;
    while (caps.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("entries_seen", 128'(caps.size()), 128'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.decode_issue_ack_in = 1'b0;
    q0.delete();
    q1.delete();
    caps.delete();
    grants.delete();
    gnt_total = 0;
    bus.req_fifo_data_f1 = '0;
    upd_empty();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.decode_issue_ack_in = 1'b0;
    bus.req_fifo_data_f1    = '0;
    bus.req_fifo_empty_f0   = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.xrq_entry_output_valid), 128'(0));
    chk("rst_count", 128'(bus.xrq_count), 128'(0));
    chk("rst_entry", 128'(bus.xrq_entry_output), 128'(0));
    chk("rst_rd_en", 128'(bus.req_fifo_rd_en_f0), 128'(0));

    // Round robin across two channels of GNT_BUF
    do_reset();
    load(0, 3, 4'h0, 0);
    load(1, 3, 4'h0, 0);
    bus.decode_issue_ack_in = 1'b1;
    wait_caps(6, 40);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 128'(grants[i]), 128'(i % 2));
      chk($sformatf("rr_sid%0d", i), 128'(caps[i][8:1]), 128'(i + 1));
      chk($sformatf("rr_ch%0d", i), 128'(caps[i][9]), 128'(i % 2));
      chk($sformatf("rr_um%0d", i), 128'(caps[i][81:74]), 128'(8'h02));
    end
    chk("rr_cmd0", 128'(caps[0][73:10]), 128'(mk(0, 0, 4'h0)));
    chk("rr_cmd5", 128'(caps[5][73:10]), 128'(mk(1, 2, 4'h0)));
    chk("rr_vld", 128'(caps[3][0]), 128'(1));

    // SPIDR/SPRR pair locks ch0 and shares one sid
    do_reset();
    load(0, 1, 4'h2, 0);
    load(0, 1, 4'h3, 1);
    load(1, 4, 4'h0, 0);
    bus.decode_issue_ack_in = 1'b1;
    wait_caps(6, 40);
    chk("lock_g0", 128'(grants[0]), 128'(0));
    chk("lock_g1", 128'(grants[1]), 128'(0));
    chk("lock_g2", 128'(grants[2]), 128'(1));
    chk("lock_sid0", 128'(caps[0][8:1]), 128'(1));
    chk("lock_um0", 128'(caps[0][81:74]), 128'(8'h08));
    chk("lock_sid1", 128'(caps[1][8:1]), 128'(1));
    chk("lock_um1", 128'(caps[1][81:74]), 128'(8'h10));
    chk("lock_sid2", 128'(caps[2][8:1]), 128'(2));
    chk("lock_ch2", 128'(caps[2][9]), 128'(1));

    // Backpressure: XRQ fills to depth 8, then one ack lets one read through
    do_reset();
    load(0, 10, 4'h0, 0);
    load(1, 10, 4'h0, 0);
    repeat (20) step();
    chk("full_count", 128'(bus.xrq_count), 128'(8));
    chk("full_valid", 128'(bus.xrq_entry_output_valid), 128'(1));
    chk("full_grants", 128'(gnt_total), 128'(8));
    chk("full_rd_en", 128'(bus.req_fifo_rd_en_f0), 128'(0));
    chk("full_head_sid", 128'(bus.xrq_entry_output[8:1]), 128'(1));
    bus.decode_issue_ack_in = 1'b1;
    step();
    bus.decode_issue_ack_in = 1'b0;
    repeat (3) step();
    chk("ack1_grants", 128'(gnt_total), 128'(9));
    chk("ack1_count", 128'(bus.xrq_count), 128'(8));
    chk("ack1_head_sid", 128'(bus.xrq_entry_output[8:1]), 128'(2));
    chk("ack1_head_ch", 128'(bus.xrq_entry_output[9]), 128'(1));

    // SID wrap 255 -> 1, zero never allocated
    do_reset();
    load(0, 256, 4'h0, 0);
    bus.decode_issue_ack_in = 1'b1;
    wait_caps(256, 600);
    if (caps.size() >= 256) begin
      int zeros = 0;
      chk("wrap_sid253", 128'(caps[252][8:1]), 128'(253));
      chk("wrap_sid254", 128'(caps[253][8:1]), 128'(254));
      chk("wrap_sid255", 128'(caps[254][8:1]), 128'(255));
      chk("wrap_sid1", 128'(caps[255][8:1]), 128'(1));
      foreach (caps[i]) if (caps[i][8:1] == 8'd0) zeros++;
      chk("wrap_no_sid0", 128'(zeros), 128'(0));
    end

    // Unknown type maps to IRR; reset mid-stream
    do_reset();
    load(1, 1, 4'hF, 0);
    load(1, 1, 4'h0, 1);
    bus.decode_issue_ack_in = 1'b1;
    wait_caps(2, 20);
    chk("irr_um", 128'(caps[0][81:74]), 128'(8'h01));
    chk("irr_sid", 128'(caps[0][8:1]), 128'(1));
    chk("irr_ch", 128'(caps[0][9]), 128'(1));
    chk("irr_next_sid", 128'(caps[1][8:1]), 128'(2));
    bus.decode_issue_ack_in = 1'b0;
    load(0, 5, 4'h0, 0);
    repeat (4) step();
    chk("mid_valid", 128'(bus.xrq_entry_output_valid), 128'(1));
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.xrq_entry_output_valid), 128'(0));
    chk("mid_rst_count", 128'(bus.xrq_count), 128'(0));
    chk("mid_rst_entry", 128'(bus.xrq_entry_output), 128'(0));
    chk("mid_rst_rd_en", 128'(bus.req_fifo_rd_en_f0), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    caps.delete();
    bus.decode_issue_ack_in = 1'b1;
    wait_caps(1, 20);
    if (caps.size() >= 1) chk("post_rst_sid", 128'(caps[0][8:1]), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
